// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks all eight 3-bit input combinations
// into a circuit under test and assembles its 8-bit truth-table code.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] exp_code,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] code,
    output logic       match
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_FINISH
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_idx;
    logic [7:0] r_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_exp;
    logic [7:0] r_code;
    logic       r_match;
    logic       r_sync1;
    logic       r_sync2;
    logic       w_settled;
    logic       w_last_idx;

    assign w_settled  = (r_cnt == LP_LAST);
    assign w_last_idx = (r_idx == 3'd7);

    assign {in1, in2, in3} = r_idx;
    assign busy  = (r_state != S_IDLE);
    assign done  = (r_state == S_FINISH);
    assign code  = r_code;
    assign match = r_match;

    // Two-flop synchronizer for the asynchronous circuit output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= dut_out;
            r_sync2 <= r_sync1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_next = S_DRIVE;
            S_DRIVE:  if (w_settled) w_next = S_SAMPLE;
            S_SAMPLE: w_next = w_last_idx ? S_FINISH : S_DRIVE;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Index, settle counter, shift register and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= 3'd0;
            r_cnt   <= 8'd0;
            r_shift <= 8'h00;
            r_exp   <= 8'h00;
            r_code  <= 8'h00;
            r_match <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx   <= 3'd0;
                        r_cnt   <= 8'd0;
                        r_shift <= 8'h00;
                        r_exp   <= exp_code;
                    end
                end
                S_DRIVE: begin
                    r_cnt <= w_settled ? 8'd0 : r_cnt + 8'd1;
                end
                S_SAMPLE: begin
                    r_shift <= {r_shift[6:0], r_sync2};
                    if (!w_last_idx) r_idx <= r_idx + 3'd1;
                end
                S_FINISH: begin
                    r_code  <= r_shift;
                    r_match <= (r_shift == r_exp);
                    r_idx   <= 3'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized self-checking bench for truth_table_sweeper
// against a combination-table reference model.
module tb_truth_table_sweeper;

    localparam int S     = 4;
    localparam int SWEEP = 8 * (S + 1) + 1;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] exp_code;
    logic       dut_out;
    logic       in1, in2, in3;
    logic       busy, done, match;
    logic [7:0] code;

    logic       f [8];
    int         n_pass;
    int         n_total;

    truth_table_sweeper #(.SETTLE_CYCLES(S)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .exp_code (exp_code),
        .dut_out  (dut_out),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .busy     (busy),
        .done     (done),
        .code     (code),
        .match    (match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Circuit-under-test model: one output bit per combination
    always_comb dut_out = f[{in1, in2, in3}];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    function automatic logic [7:0] ref_code();
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 8; i++) c[7 - i] = f[i];
        return c;
    endfunction

    task automatic set_fn(input logic [7:0] tt);
        // tt bit 7 is combination 0, matching the usual code notation
        for (int i = 0; i < 8; i++) f[i] = tt[7 - i];
    endtask

    task automatic sweep(input string tag, input logic [7:0] exp,
                         input int extra_at);
        int         cyc;
        int         bcnt;
        int         dones;
        int         nchg;
        logic [23:0] walk;
        logic [2:0] last;
        logic [7:0] want;
        want = ref_code();
        @(negedge clk);
        start    = 1'b1;
        exp_code = exp;
        @(negedge clk);
        start    = 1'b0;
        exp_code = ~exp;
        cyc   = 0;
        bcnt  = 0;
        dones = 0;
        last  = {in1, in2, in3};
        walk  = {21'd0, last};
        nchg  = 1;
        while (busy && cyc < 400) begin
            bcnt++;
            if (done) dones++;
            if ({in1, in2, in3} != last) begin
                last = {in1, in2, in3};
                walk = {walk[20:0], last};
                nchg++;
            end
            start = (cyc == extra_at);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, " busy_len"}, bcnt, SWEEP);
        check({tag, " dones"}, dones, 1);
        check({tag, " code"}, code, want);
        check({tag, " match"}, match, (want == exp));
        check({tag, " walk"}, {nchg[7:0], walk}, {8'd8, 24'o01234567});
        check({tag, " idle"}, {busy, done, in1, in2, in3}, 5'b0);
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        rst      = 1'b1;
        start    = 1'b0;
        exp_code = 8'h00;
        set_fn(8'h00);
        repeat (3) @(negedge clk);
        check("reset", {busy, done, match, in1, in2, in3, code}, 14'd0);
        rst = 1'b0;
        @(negedge clk);

        set_fn(8'hBD);
        sweep("bd_match", 8'hBD, -1);
        for (int i = 0; i < 8; i++) f[i] = i[0];
        sweep("in3", 8'h55, -1);
        set_fn(8'h00);
        sweep("zero", 8'hBC, -1);
        set_fn(8'hFF);
        sweep("ones", 8'hBC, -1);
        set_fn(8'hBD);
        sweep("bd_mis", 8'hBC, -1);
        sweep("restart", 8'hBD, 3 * (S + 1) + 1);

        // Reset in the middle of combination 5
        begin
            int cyc;
            int dones;
            set_fn(8'hBD);
            @(negedge clk);
            start    = 1'b1;
            exp_code = 8'hBD;
            @(negedge clk);
            start = 1'b0;
            cyc   = 0;
            dones = 0;
            while ({in1, in2, in3} != 3'd5 && cyc < 200) begin
                if (done) dones++;
                @(negedge clk);
                cyc++;
            end
            check("reach_idx5", cyc < 200, 1);
            @(negedge clk);
            rst = 1'b1;
            #1;
            check("mid_rst", {busy, done, match, in1, in2, in3, code}, 14'd0);
            check("mid_rst_dones", dones, 0);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            check("post_rst_idle", {busy, done}, 2'b0);
            sweep("after_rst", 8'hBD, -1);
        end

        for (int k = 0; k < 6; k++) begin
            logic [7:0] tt;
            logic [7:0] e;
            tt = 8'($urandom);
            e  = ($urandom_range(0, 1) == 1) ? tt : 8'($urandom);
            for (int i = 0; i < 8; i++) f[i] = tt[i];
            sweep($sformatf("rand%0d", k), e, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
